// File: rtl/lsb_queue_pkg.sv
// rtl/lsb_queue_pkg.sv - shared defaults, funct3 codes, encodings and helpers for the load/store buffer
package lsb_queue_pkg;

    localparam int DEF_LSB_SIZE_BIT = 3;
    localparam int DEF_ROB_SIZE_BIT = 4;
    localparam int DEF_NUM_CDB      = 2;
    localparam logic [1:0] DEF_IO_ADDR_HI = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_MEM   = 2'd1,
        FLUSH_WAIT = 2'd2
    } lsb_state_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] value;
    } cdb_hit_t;

    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: size_of = SIZE_BYTE;
            F3_LH, F3_LHU: size_of = SIZE_HALF;
            default:       size_of = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsb_load_ext.sv
// rtl/lsb_load_ext.sv - funct3-driven sign/zero extension of right-aligned load data
import lsb_queue_pkg::*;

module lsb_load_ext (
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    always_comb begin
        value = rdata;
        case (funct3)
            F3_LB:   value = {{24{rdata[7]}}, rdata[7:0]};
            F3_LH:   value = {{16{rdata[15]}}, rdata[15:0]};
            F3_LBU:  value = {24'd0, rdata[7:0]};
            F3_LHU:  value = {16'd0, rdata[15:0]};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/lsb_queue.sv
// rtl/lsb_queue.sv - in-order load/store buffer with CDB wake-up and single outstanding memory access
import lsb_queue_pkg::*;

module lsb_queue #(
    parameter int         LSB_SIZE_BIT = DEF_LSB_SIZE_BIT,
    parameter int         ROB_SIZE_BIT = DEF_ROB_SIZE_BIT,
    parameter int         NUM_CDB      = DEF_NUM_CDB,
    parameter logic [1:0] IO_ADDR_HI   = DEF_IO_ADDR_HI
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear_in,
    output logic                         lsb_full,
    input  logic                         inst_input,
    input  logic                         in_is_store,
    input  logic [2:0]                   in_funct3,
    input  logic [31:0]                  in_imm,
    input  logic [31:0]                  lsb_r1_val,
    input  logic [31:0]                  lsb_r2_val,
    input  logic                         lsb_r1_has_dep,
    input  logic                         lsb_r2_has_dep,
    input  logic [ROB_SIZE_BIT-1:0]      lsb_r1_dep,
    input  logic [ROB_SIZE_BIT-1:0]      lsb_r2_dep,
    input  logic [ROB_SIZE_BIT-1:0]      in_rob_id,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_SIZE_BIT-1:0] cdb_rob_id,
    input  logic [NUM_CDB*32-1:0]        cdb_value,
    input  logic [ROB_SIZE_BIT-1:0]      rob_head_id,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [1:0]                   mem_size,
    input  logic                         mem_done,
    input  logic [31:0]                  mem_rdata,
    output logic                         lsb_fi,
    output logic [31:0]                  lsb_value,
    output logic [ROB_SIZE_BIT-1:0]      lsb_rob_id
);

    localparam int DEPTH = 1 << LSB_SIZE_BIT;
    localparam int CNT_W = LSB_SIZE_BIT + 1;

    typedef logic [LSB_SIZE_BIT-1:0] idx_t;
    typedef logic [ROB_SIZE_BIT-1:0] rob_t;

    logic [DEPTH-1:0] busy, is_store, r1_has_dep, r2_has_dep;
    logic [2:0]       funct3 [DEPTH];
    logic [31:0]      imm    [DEPTH];
    logic [31:0]      r1_val [DEPTH];
    logic [31:0]      r2_val [DEPTH];
    rob_t             r1_dep [DEPTH];
    rob_t             r2_dep [DEPTH];
    rob_t             rob_id [DEPTH];

    idx_t             head, tail;
    logic [CNT_W-1:0] count;
    lsb_state_e       state, state_next;

    cdb_hit_t         wake1 [DEPTH];
    cdb_hit_t         wake2 [DEPTH];
    cdb_hit_t         byp1, byp2;

    logic [31:0]      head_addr, ext_value;
    logic             head_is_io, head_ready, can_issue;
    logic             flush, enq, deq, issue, done_any;

    // Loop runs high-to-low so the lowest-numbered matching channel is the last writer.
    function automatic cdb_hit_t cdb_match(input rob_t dep,
                                           input logic [NUM_CDB-1:0] v,
                                           input logic [NUM_CDB*ROB_SIZE_BIT-1:0] ids,
                                           input logic [NUM_CDB*32-1:0] vals);
        cdb_match = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (v[k] && ids[k*ROB_SIZE_BIT +: ROB_SIZE_BIT] == dep) begin
                cdb_match.hit   = 1'b1;
                cdb_match.value = vals[k*32 +: 32];
            end
        end
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = cdb_match(r1_dep[i], cdb_valid, cdb_rob_id, cdb_value);
            wake2[i] = cdb_match(r2_dep[i], cdb_valid, cdb_rob_id, cdb_value);
        end
        byp1 = cdb_match(lsb_r1_dep, cdb_valid, cdb_rob_id, cdb_value);
        byp2 = cdb_match(lsb_r2_dep, cdb_valid, cdb_rob_id, cdb_value);
    end

    assign lsb_full   = (count == CNT_W'(DEPTH));
    assign head_addr  = r1_val[head] + imm[head];
    assign head_is_io = (head_addr[17:16] == IO_ADDR_HI);
    assign head_ready = busy[head] && !r1_has_dep[head] && (!is_store[head] || !r2_has_dep[head]);
    // Stores and I/O loads have side effects, so they wait until they are the oldest in the ROB.
    assign can_issue  = (state == IDLE) && head_ready && !clear_in &&
                        ((!is_store[head] && !head_is_io) || rob_id[head] == rob_head_id);

    lsb_load_ext u_load_ext (
        .funct3 (funct3[head]),
        .rdata  (mem_rdata),
        .value  (ext_value)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (can_issue) state_next = WAIT_MEM;
            WAIT_MEM: begin
                if (mem_done)      state_next = IDLE;
                else if (clear_in) state_next = FLUSH_WAIT;
            end
            FLUSH_WAIT: if (mem_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        flush    = rdy_in && clear_in;
        enq      = rdy_in && inst_input && !lsb_full && !clear_in;
        deq      = rdy_in && (state == WAIT_MEM) && mem_done && !clear_in;
        issue    = rdy_in && can_issue;
        done_any = rdy_in && (state != IDLE) && mem_done;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                busy[head] <= 1'b0;
                head       <= head + idx_t'(1);
            end
            if (enq) begin
                busy[tail] <= 1'b1;
                tail       <= tail + idx_t'(1);
            end
            if (enq && !deq)
                count <= count + CNT_W'(1);
            else if (deq && !enq)
                count <= count - CNT_W'(1);
        end
    end

    // Entry payload needs no reset: it is only observed while the busy bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && r1_has_dep[i] && wake1[i].hit) begin
                    r1_val[i]     <= wake1[i].value;
                    r1_has_dep[i] <= 1'b0;
                end
                if (busy[i] && r2_has_dep[i] && wake2[i].hit) begin
                    r2_val[i]     <= wake2[i].value;
                    r2_has_dep[i] <= 1'b0;
                end
            end
            if (enq) begin
                is_store[tail]   <= in_is_store;
                funct3[tail]     <= in_funct3;
                imm[tail]        <= in_imm;
                rob_id[tail]     <= in_rob_id;
                r1_dep[tail]     <= lsb_r1_dep;
                r2_dep[tail]     <= lsb_r2_dep;
                r1_val[tail]     <= (lsb_r1_has_dep && byp1.hit) ? byp1.value : lsb_r1_val;
                r2_val[tail]     <= (lsb_r2_has_dep && byp2.hit) ? byp2.value : lsb_r2_val;
                r1_has_dep[tail] <= lsb_r1_has_dep && !byp1.hit;
                r2_has_dep[tail] <= lsb_r2_has_dep && !byp2.hit;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_size   <= '0;
            lsb_fi     <= 1'b0;
            lsb_value  <= '0;
            lsb_rob_id <= '0;
        end else if (rdy_in) begin
            lsb_fi <= 1'b0;
            if (issue) begin
                mem_req   <= 1'b1;
                mem_we    <= is_store[head];
                mem_addr  <= head_addr;
                mem_wdata <= r2_val[head];
                mem_size  <= size_of(funct3[head]);
            end
            if (done_any) begin
                mem_req <= 1'b0;
                if (deq) begin
                    lsb_fi     <= 1'b1;
                    lsb_rob_id <= rob_id[head];
                    lsb_value  <= is_store[head] ? 32'd0 : ext_value;
                end
            end
        end
    end

endmodule
